// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer and its next-PC helper.
// Reset PC default, next-PC select encodings and the fetch state encoding.
package ifetch_pkg;

    localparam logic [31:0] IFETCH_RESET_PC = 32'h0000_3000;

    typedef enum logic [1:0] {
        NPC_PC4 = 2'b00,
        NPC_BR  = 2'b01,
        NPC_J   = 2'b10,
        NPC_JR  = 2'b11
    } npc_sel_e;

    typedef enum logic [1:0] {
        FS_IDLE = 2'b00,
        FS_REQ  = 2'b01,
        FS_LOAD = 2'b10
    } fetch_state_e;

endpackage

// File: rtl/ifetch_npc_calc.sv
// Combinational next-PC: sequential, PC-relative branch, pseudo-direct jump, register jump.
// Also used by the controller to form link addresses, so it stays free of state.
module npc_calc
    import ifetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  npc_sel,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    input  logic [31:0] ra_val,
    output logic [31:0] pc4,
    output logic [31:0] npc
);

    logic [31:0] br_off;

    assign pc4    = pc + 32'd4;
    // Branch offset counts words, hence the two-bit shift after sign extension.
    assign br_off = {{14{imm16[15]}}, imm16, 2'b00};

    always_comb begin
        npc = pc4;
        case (npc_sel_e'(npc_sel))
            NPC_PC4: npc = pc4;
            NPC_BR:  npc = pc4 + br_off;
            NPC_J:   npc = {pc4[31:28], imm26, 2'b00};
            NPC_JR:  npc = ra_val;
            default: npc = pc4;
        endcase
    end

endmodule

// File: rtl/ifetch.sv
// Multicycle fetch sequencer: IDLE -> REQ (wait for imem_ready) -> LOAD (irwr strobe).
// Build with IFETCH_ALIGN_CHK_EN to reject fetches from a misaligned PC via fetch_err.
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IFETCH_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_req,
    input  logic        pcwr,
    input  logic [1:0]  npc_sel,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    input  logic [31:0] ra_val,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ins,
    output logic        irwr,
    output logic [31:0] pc,
    output logic        busy,
    output logic        fetch_err
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  ins_q;
    logic         imem_req_q;
    logic         irwr_q;
    logic         fetch_err_q;
    logic [31:0]  npc;
    logic [31:0]  pc4;
    logic [31:0]  pc_d;

    npc_calc u_npc_calc (
        .pc      (pc_q),
        .npc_sel (npc_sel),
        .imm16   (imm16),
        .imm26   (imm26),
        .ra_val  (ra_val),
        .pc4     (pc4),
        .npc     (npc)
    );

    // A same-cycle commit is visible to the fetch it accompanies.
    assign pc_d = pcwr ? npc : pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FS_IDLE;
            pc_q        <= RESET_PC;
            ins_q       <= 32'd0;
            imem_req_q  <= 1'b0;
            irwr_q      <= 1'b0;
            fetch_err_q <= 1'b0;
        end else begin
            irwr_q      <= 1'b0;
            fetch_err_q <= 1'b0;
            case (state_q)
                FS_IDLE: begin
                    pc_q <= pc_d;
                    if (fetch_req) begin
`ifdef IFETCH_ALIGN_CHK_EN
                        if (pc_d[1:0] != 2'b00) begin
                            fetch_err_q <= 1'b1;
                        end else begin
                            state_q    <= FS_REQ;
                            imem_req_q <= 1'b1;
                        end
`else
                        state_q    <= FS_REQ;
                        imem_req_q <= 1'b1;
`endif
                    end
                end
                FS_REQ: begin
                    if (imem_ready) begin
                        ins_q      <= imem_rdata;
                        imem_req_q <= 1'b0;
                        irwr_q     <= 1'b1;
                        state_q    <= FS_LOAD;
                    end
                end
                FS_LOAD: begin
                    state_q <= FS_IDLE;
                end
                default: begin
                    state_q    <= FS_IDLE;
                    imem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = pc_q;
    assign ins       = ins_q;
    assign irwr      = irwr_q;
    assign pc        = pc_q;
    assign busy      = (state_q != FS_IDLE);
    assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: directed test-plan steps followed by randomized
// commit/fetch traffic, checked against a behavioural next-PC and fetch model.
module tb_ifetch;

    logic        clk;
    logic        rst_n;
    logic        fetch_req;
    logic        pcwr;
    logic [1:0]  npc_sel;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] ra_val;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] ins;
    logic        irwr;
    logic [31:0] pc;
    logic        busy;
    logic        fetch_err;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] exp_pc;
    logic [31:0] exp_ins;

    ifetch dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fetch_req  (fetch_req),
        .pcwr       (pcwr),
        .npc_sel    (npc_sel),
        .imm16      (imm16),
        .imm26      (imm26),
        .ra_val     (ra_val),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .ins        (ins),
        .irwr       (irwr),
        .pc         (pc),
        .busy       (busy),
        .fetch_err  (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Architectural next-PC rules in plain arithmetic.
    function automatic logic [31:0] ref_npc(input logic [31:0] cur, input logic [1:0] sel,
                                            input logic [15:0] i16, input logic [25:0] i26,
                                            input logic [31:0] ra);
        longint off;
        case (sel)
            2'd0: return cur + 32'd4;
            2'd1: begin
                off = longint'($signed(i16)) * 4;
                return 32'(longint'(cur) + 4 + off);
            end
            2'd2: return ((cur + 32'd4) & 32'hF000_0000) | (32'(i26) * 32'd4);
            default: return ra;
        endcase
    endfunction

    task automatic commit(input logic [1:0] sel, input logic [15:0] i16,
                          input logic [25:0] i26, input logic [31:0] ra, input string tag);
        pcwr = 1'b1; npc_sel = sel; imm16 = i16; imm26 = i26; ra_val = ra;
        exp_pc = ref_npc(exp_pc, sel, i16, i26, ra);
        tick();
        pcwr = 1'b0;
        check(tag, pc, exp_pc);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // Full fetch with 'waits' not-ready cycles; 'noise' toggles pcwr/fetch_req while busy.
    task automatic do_fetch(input int waits, input logic [31:0] data, input logic with_pcwr,
                            input logic noise, input string tag);
        fetch_req = 1'b1;
        imem_ready = 1'b0;
        if (with_pcwr) begin
            pcwr = 1'b1; npc_sel = 2'd0;
            exp_pc = ref_npc(exp_pc, 2'd0, imm16, imm26, ra_val);
        end
        tick();
        fetch_req = 1'b0; pcwr = 1'b0;
        for (int i = 0; i <= waits; i++) begin
            check({tag, "_req"}, 32'(imem_req), 32'd1);
            check({tag, "_addr"}, imem_addr, exp_pc);
            check({tag, "_pc"}, pc, exp_pc);
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_irwr_wait"}, 32'(irwr), 32'd0);
            check({tag, "_ins_hold"}, ins, exp_ins);
            imem_ready = (i == waits);
            imem_rdata = (i == waits) ? data : $urandom;
            if (noise) begin
                pcwr = 1'b1; fetch_req = 1'b1; npc_sel = 2'($urandom);
                ra_val = $urandom;
            end
            tick();
        end
        imem_ready = 1'b0;
        exp_ins = data;
        check({tag, "_irwr"}, 32'(irwr), 32'd1);
        check({tag, "_ins"}, ins, exp_ins);
        check({tag, "_req_off"}, 32'(imem_req), 32'd0);
        check({tag, "_busy_load"}, 32'(busy), 32'd1);
        tick();
        pcwr = 1'b0; fetch_req = 1'b0;
        check({tag, "_irwr_off"}, 32'(irwr), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
        check({tag, "_ins_kept"}, ins, exp_ins);
        check({tag, "_pc_kept"}, pc, exp_pc);
    endtask

    initial begin
        rst_n = 1'b0; fetch_req = 1'b0; pcwr = 1'b0; npc_sel = 2'd0;
        imm16 = 16'd0; imm26 = 26'd0; ra_val = 32'd0;
        imem_ready = 1'b0; imem_rdata = 32'd0;
        exp_pc = 32'h0000_3000; exp_ins = 32'd0;

        #12;
        check("rst_pc", pc, 32'h0000_3000);
        check("rst_ins", ins, 32'd0);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_irwr", 32'(irwr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(fetch_err), 32'd0);
        rst_n = 1'b1;
        tick();

        do_fetch(0, 32'h2008_0005, 1'b0, 1'b0, "fetch0");
        do_fetch(3, 32'h8C01_0004, 1'b0, 1'b0, "fetch_wait3");

        for (int i = 0; i < 4; i++) commit(2'd0, 16'd0, 26'd0, 32'd0, "pc4");
        check("pc_3010", pc, 32'h0000_3010);
        commit(2'd1, 16'hFFFE, 26'd0, 32'd0, "br");
        check("br_abs", pc, 32'h0000_300C);
        commit(2'd2, 16'd0, 26'h000_0C05, 32'd0, "jmp");
        check("jmp_abs", pc, 32'h0000_3014);
        commit(2'd3, 16'd0, 26'd0, 32'h0000_3100, "jr");
        check("jr_abs", pc, 32'h0000_3100);

        do_fetch(2, 32'h1234_5678, 1'b0, 1'b1, "ignored_cmds");
        do_fetch(0, 32'hCAFE_F00D, 1'b1, 1'b0, "pcwr_and_fetch");
        check("pcwr_fetch_addr", pc, 32'h0000_3104);

        // Asynchronous abort in the middle of a request.
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        check("abort_pre_req", 32'(imem_req), 32'd1);
        imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        #2 rst_n = 1'b0;
        #1;
        exp_pc = 32'h0000_3000; exp_ins = 32'd0;
        check("abort_req", 32'(imem_req), 32'd0);
        check("abort_pc", pc, exp_pc);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_irwr", 32'(irwr), 32'd0);
        #2 rst_n = 1'b1;
        tick();
        check("abort_irwr_after", 32'(irwr), 32'd0);
        check("abort_ins", ins, 32'd0);
        imem_ready = 1'b0;
        tick();
        check("abort_idle", 32'(busy), 32'd0);

        commit(2'd3, 16'd0, 26'd0, 32'h0000_3002, "jr_mis");
`ifdef IFETCH_ALIGN_CHK_EN
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        check("mis_err", 32'(fetch_err), 32'd1);
        check("mis_req", 32'(imem_req), 32'd0);
        check("mis_busy", 32'(busy), 32'd0);
        tick();
        check("mis_err_pulse", 32'(fetch_err), 32'd0);
        check("mis_req_after", 32'(imem_req), 32'd0);
        check("mis_pc", pc, 32'h0000_3002);
`else
        do_fetch(1, 32'h0BAD_0002, 1'b0, 1'b0, "mis_fetch");
        check("mis_err_tied", 32'(fetch_err), 32'd0);
`endif

        commit(2'd3, 16'd0, 26'd0, 32'hFFFF_FFFC, "wrap_set");
        commit(2'd0, 16'd0, 26'd0, 32'd0, "wrap");
        check("wrap_zero", pc, 32'd0);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(1, 0) == 1)
                commit(2'($urandom), 16'($urandom), 26'($urandom),
                       $urandom & 32'hFFFF_FFFC, "rnd_commit");
            else
                do_fetch(int'($urandom_range(3, 0)), $urandom, 1'($urandom),
                         1'($urandom), "rnd_fetch");
            check("rnd_err", 32'(fetch_err), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
